adder_reduce_ctrl: RTL
======================

# adder_reduce_ctrl

Reduction controller that sums a burst of signed samples by driving an external pipelined `adder` instance. It acts as the initiator on the adder's operand/valid interface and collects its registered results. It sits between a sample stream producer and the `adder`, and emits one wrap-around sum per burst. The adder runs pairwise; all reordering and buffering is internal.

## Interface
- `BIT`, 40, sample, operand and sum width (two's complement); must match the attached `adder`.
- `DEPTH`, 8, operand store entries (power of 2, ≥4).
- `ADD_LAT`, 1, adder latency in cycles from `add_valid` to `add_res_valid`; used only in documented timing.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `in_data`  in  BIT  signed sample.
- `in_last`  in  1  marks the final sample of a burst.
- `add_valid`  out  1  drives the adder's `data_in_valid`.
- `add_a`, `add_b`  out  BIT  drive the adder's `A_in` and `B_in`.
- `add_res_valid`  in  1  from the adder's `data_out_valid`.
- `add_res`  in  BIT  from the adder's `C_out`.
- `out_valid`  out  1  one-cycle pulse carrying the burst sum.
- `out_data`  out  BIT  burst sum, modulo 2^BIT.
- `out_cnt`  out  16  burst sample count; present only with `ADDER_REDUCE_CNT_EN`.

## Operation
- Operand store: a circular buffer with `DEPTH` entries and a `count` register. It has two write ports (input sample, adder result) and a two-entry read at the head.
- Write order when both writes happen in one cycle: the result is written first, then the sample.
- `inflight` counter: increments on `add_valid` and decrements on `add_res_valid`. Both in the same cycle leaves it unchanged.
- Issue: when registered `count ≥ 2`, pop the two head entries. Drive `add_a` = head and `add_b` = head+1, with `add_valid`=1 for that cycle. This repeats on every cycle where the condition holds.
- `count_next = count − 2·issue − emit + in_fire + add_res_valid`.
- FSM states:
  - ACCUM: accepts samples. On a fire with `in_last`, go to DRAIN.
  - DRAIN: `in_ready`=0. When `count==1 && inflight==0 && !add_res_valid`, go to EMIT.
  - EMIT: `out_valid`=1 and `out_data`=head; pop the head and go to ACCUM.
- `in_ready` = (state==ACCUM) && (count + inflight < DEPTH). Issues never raise occupancy, so the store cannot overflow.
- Arithmetic is done solely by the external adder, which wraps modulo 2^BIT. No saturation and no overflow flag.
- A result whose `add_res_valid` arrives while in ACCUM is stored normally.
- If `add_res_valid` arrives while `inflight==0`, the result is ignored and `inflight` stays at 0. Treat this as a protocol error.

## Timing
- Reset values: `in_ready`=0 during reset and 1 the cycle after reset; `add_valid`=0, `add_a`=`add_b`=0, `out_valid`=0, `out_data`=0, `out_cnt`=0. Also on reset: `count`=`inflight`=0 and state=ACCUM.
- Reset mid-burst: the store is flushed and in-flight results are discarded. Any `add_res_valid` arriving within `ADD_LAT` cycles after reset is dropped because `inflight`=0.
- `add_a`, `add_b` and `add_valid` are registered and driven in the issue cycle.
- Single-sample burst (fire with `in_last` at cycle t): `out_valid` at t+2.
- Two-sample burst (fires at t and t+1):
  - issue at t+2;
  - result at t+2+ADD_LAT;
  - `out_valid` at t+4+ADD_LAT.
- General case: `out_valid` is asserted 2 cycles after the last result is written with `count==1`.
- Back-to-back bursts: the next burst's first sample is accepted the cycle after `out_valid`.
- Full store: `in_ready` drops in the cycle that `count+inflight` reaches `DEPTH`. It recovers the cycle after an issue reduces occupancy.

## Configuration
- `ADDER_REDUCE_CNT_EN` defined:
  - a 16-bit counter increments on each sample fire;
  - it is latched to `out_cnt` in EMIT and cleared on the transition back to ACCUM;
  - it wraps at 2^16.
- Not defined: the `out_cnt` port and the counter are absent. All other behaviour is identical.

## Test plan
- Burst 1,2,3,4 (last on 4), ADD_LAT=1 -> exactly one `out_valid` with `out_data`=10. `add_valid` pulses exactly 3 times.
- Single sample −5 with `in_last` at cycle t -> `out_valid` at t+2 with `out_data`=−5. No `add_valid` is issued.
- BIT=40, burst 2^39−1 and 1 -> `out_data` = −2^39 (wrap).
- DEPTH=4, 10 samples of value 3 streamed with `in_valid` held high:
  - `in_ready` deasserts at least once;
  - `out_data`=30;
  - `count+inflight` never exceeds 4.
- Assert `rst` for 1 cycle mid-burst while one add is in flight, then run burst 7,8 -> `out_data`=15. No stale result is included.
- `ADDER_REDUCE_CNT_EN` defined, burst of 5 ones -> `out_data`=5 and `out_cnt`=5 in the `out_valid` cycle. Bursts of 2 then 3 -> `out_cnt` reads 2, then 3.

Source files
------------

// File: rtl/adder_reduce_ctrl.sv
// Burst reduction controller: sums signed samples pairwise through an external pipelined adder.
// Define ADDER_REDUCE_CNT_EN to add the per-burst sample counter on out_cnt.
module adder_reduce_ctrl #(
    parameter int unsigned BIT     = 40,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BIT-1:0] in_data,
    input  logic           in_last,
    output logic           add_valid,
    output logic [BIT-1:0] add_a,
    output logic [BIT-1:0] add_b,
    input  logic           add_res_valid,
    input  logic [BIT-1:0] add_res,
    output logic           out_valid,
    output logic [BIT-1:0] out_data
`ifdef ADDER_REDUCE_CNT_EN
    ,
    output logic [15:0]    out_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || ADD_LAT == 0) begin : g_param_check
        $error("adder_reduce_ctrl: DEPTH must be a power of 2 >= 4 and ADD_LAT >= 1");
    end

    typedef enum logic [1:0] {ACCUM, DRAIN, EMIT} state_t;

    state_t          state, state_next;
    logic [BIT-1:0]  mem [DEPTH];
    logic [AW-1:0]   head, head_next;
    logic [CW-1:0]   count, count_next;
    logic [CW-1:0]   inflight, inflight_next;
    logic [CW:0]     occ_next;
    logic [AW-1:0]   wr_res, wr_in;
    logic [1:0]      pop;
    logic            in_fire, issue, emit, res_accept, issue_next;
    logic [CW-1:0]   rel [2];
    logic [BIT-1:0]  view [2];

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    // Next state, store bookkeeping, and a look-ahead of the head pair after this cycle's writes.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        in_fire    = in_valid && in_ready;
        issue      = count >= CW'(2);
        res_accept = add_res_valid && (inflight != '0);
        case (state)
            ACCUM: if (in_fire && in_last) state_next = DRAIN;
            DRAIN: if (count == CW'(1) && inflight == '0 && !add_res_valid) state_next = EMIT;
            EMIT: begin
                emit       = 1'b1;
                state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase

        pop           = {issue, 1'b0} + {1'b0, emit};
        count_next    = count - CW'(pop) + CW'(in_fire) + CW'(res_accept);
        inflight_next = inflight + CW'(issue) - CW'(res_accept);
        head_next     = head + AW'(pop);
        occ_next      = (CW+1)'(count_next) + (CW+1)'(inflight_next);
        issue_next    = count_next >= CW'(2);
        wr_res        = AW'(CW'(head) + count);
        wr_in         = AW'(CW'(head) + count + CW'(res_accept));

        // Result lands before the sample, so it occupies the lower position.
        for (int k = 0; k < 2; k++) begin
            rel[k] = CW'(pop) + CW'(k);
            if (rel[k] < count)                      view[k] = mem[AW'(CW'(head) + rel[k])];
            else if (rel[k] == count && res_accept)  view[k] = add_res;
            else                                     view[k] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (res_accept) mem[wr_res] <= add_res;
        if (in_fire)    mem[wr_in]  <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            count     <= '0;
            inflight  <= '0;
            in_ready  <= 1'b0;
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            head      <= head_next;
            count     <= count_next;
            inflight  <= inflight_next;
            in_ready  <= (state_next == ACCUM) && (occ_next < (CW+1)'(DEPTH));
            add_valid <= issue_next;
            add_a     <= issue_next ? view[0] : '0;
            add_b     <= issue_next ? view[1] : '0;
            out_valid <= (state_next == EMIT);
            // Entering EMIT guarantees a single stored entry and no writes this cycle.
            if (state_next == EMIT) out_data <= mem[head];
        end
    end

`ifdef ADDER_REDUCE_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            out_cnt <= '0;
        end else begin
            if (state == EMIT)  cnt <= '0;
            else if (in_fire)   cnt <= cnt + 16'd1;
            if (state_next == EMIT) out_cnt <= cnt;
        end
    end
`endif

endmodule
